// File: rtl/ifetch_pkg.sv
// -----------------------------------------------------------------------------
// ifetch_pkg
// Shared types and constants for the instruction fetch stage:
//   fetch_state_e  - fetch FSM states (BOOT, RUN, FLUSH)
//   OPC_OP_IMM/OPC_OP - the two ALU opcodes the downstream decoder handles
//   INSTR_W/PC_STEP   - instruction width and sequential PC increment
//   q_entry_t      - instruction queue entry {instr, pc, illegal}
//   is_illegal()   - classifies a word the decoder cannot execute
// -----------------------------------------------------------------------------
package ifetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    localparam int          INSTR_W    = 32;
    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
        logic               illegal;
    } q_entry_t;

    // Anything that is not a 32-bit encoding of OP-IMM or OP is illegal
    // for the ALU-only decoder.
    function automatic logic is_illegal(input logic [INSTR_W-1:0] w);
        return (w[1:0] != 2'b11) ||
               ((w[6:0] != OPC_OP_IMM) && (w[6:0] != OPC_OP));
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// -----------------------------------------------------------------------------
// ifetch_fifo
// Small synchronous FIFO with flush, used both as the instruction queue and
// as the FIFO of issued PCs that pairs each memory response with its address.
// The head entry is read combinationally from the storage array.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (clears pointers/count)
//   i_push      - write i_data (ignored when full or flushing)
//   i_pop       - drop the head entry (ignored when empty or flushing)
//   i_flush     - empty the FIFO; wins over push and pop
//   i_data      - write data
//   o_head      - current head entry (meaningful when o_count != 0)
//   o_count     - number of stored entries
// -----------------------------------------------------------------------------
module ifetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [W-1:0]     i_data,
    output logic [W-1:0]     o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam int             PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_push = i_push && !i_flush && (r_count < CNT_W'(DEPTH));
    assign w_pop  = i_pop && !i_flush && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage: owns the PC, issues word reads to instruction
// memory, queues returned instructions in order and hands them to the
// decoder over valid/ready. A redirect flushes queued instructions and
// marks every in-flight read to be discarded when it returns.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   imem_req/imem_addr    - read request and word-aligned address
//   imem_rvalid/imem_rdata- in-order read responses
//   redirect_valid/_pc    - restart fetch at redirect_pc (bits [1:0] dropped)
//   instr_valid/ready     - decoder handshake
//   instr/instr_pc        - instruction word and its PC (hold when empty)
//   instr_illegal         - only with IFETCH_ILLEGAL_CHK_EN defined: head
//                           instruction is not an OP/OP-IMM ALU op
// Build option: define IFETCH_ILLEGAL_CHK_EN to add instr_illegal.
// -----------------------------------------------------------------------------
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter int          CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
`ifdef IFETCH_ILLEGAL_CHK_EN
    output logic        instr_illegal,
`endif
    output logic [31:0] instr_pc
);

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      w_redir_pc;
    logic [CNT_W-1:0] r_kill;
    logic [CNT_W-1:0] w_kill_nxt;
    logic [CNT_W-1:0] w_outstanding;
    logic [CNT_W-1:0] w_out_nxt;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_inflight;
    logic             w_rsp;
    logic             w_keep;
    logic             w_drop;
    logic             w_pop_q;
    logic [31:0]      w_rsp_pc;
    logic [31:0]      w_head_instr;
    logic [31:0]      w_head_pc;
    logic [31:0]      r_instr;
    logic [31:0]      r_instr_pc;

    assign w_redir_pc = redirect_pc & ~32'h3;

    // Issue is capped on outstanding + buffered so a response always has
    // a queue slot waiting for it.
    assign w_inflight = {1'b0, w_outstanding} + {1'b0, w_count};
    assign imem_req   = (r_state != BOOT) && (w_inflight < (CNT_W+1)'(DEPTH));
    assign imem_addr  = r_pc;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp   = imem_rvalid && (w_outstanding != '0);
    assign w_drop  = w_rsp && (r_kill != '0);
    assign w_keep  = w_rsp && (r_kill == '0) && !redirect_valid;
    assign w_pop_q = instr_valid && instr_ready && !redirect_valid;

    assign w_out_nxt = w_outstanding + CNT_W'(imem_req) - CNT_W'(w_rsp);

    always_comb begin
        w_kill_nxt  = r_kill;
        w_state_nxt = r_state;
        // Every read still in flight after this cycle belongs to the old
        // path, including one issued in the redirect cycle itself.
        if (redirect_valid)  w_kill_nxt = w_out_nxt;
        else if (w_drop)     w_kill_nxt = r_kill - 1'b1;
        case (r_state)
            BOOT:    w_state_nxt = RUN;
            RUN:     if (redirect_valid && (w_kill_nxt != '0)) w_state_nxt = FLUSH;
            FLUSH:   if (w_kill_nxt == '0) w_state_nxt = RUN;
            default: w_state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_kill  <= '0;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
            if (redirect_valid) r_pc <= w_redir_pc;
            else if (imem_req)  r_pc <= r_pc + PC_STEP;
        end
    end

    // Issued PCs; its occupancy is the outstanding-read count, and killed
    // reads pop it too so pairing stays aligned.
    ifetch_fifo #(.W(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_pc_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (imem_req),
        .i_pop   (w_rsp),
        .i_flush (1'b0),
        .i_data  (r_pc),
        .o_head  (w_rsp_pc),
        .o_count (w_outstanding)
    );

`ifdef IFETCH_ILLEGAL_CHK_EN
    localparam int Q_W = $bits(q_entry_t);
    q_entry_t w_q_in;
    q_entry_t w_q_head;
    logic     r_illegal;

    assign w_q_in       = '{instr: imem_rdata, pc: w_rsp_pc, illegal: is_illegal(imem_rdata)};
    assign w_head_instr = w_q_head.instr;
    assign w_head_pc    = w_q_head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_illegal <= 1'b0;
        else if (instr_valid) r_illegal <= w_q_head.illegal;
    end

    assign instr_illegal = instr_valid ? w_q_head.illegal : r_illegal;
`else
    localparam int Q_W = 2 * INSTR_W;
    logic [Q_W-1:0] w_q_in;
    logic [Q_W-1:0] w_q_head;

    assign w_q_in       = {imem_rdata, w_rsp_pc};
    assign w_head_instr = w_q_head[Q_W-1:32];
    assign w_head_pc    = w_q_head[31:0];
`endif

    ifetch_fifo #(.W(Q_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_instr_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_keep),
        .i_pop   (w_pop_q),
        .i_flush (redirect_valid),
        .i_data  (w_q_in),
        .o_head  (w_q_head),
        .o_count (w_count)
    );

    assign instr_valid = (w_count != '0);

    // Keep the last presented head so outputs hold steady while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else if (instr_valid) begin
            r_instr    <= w_head_instr;
            r_instr_pc <= w_head_pc;
        end
    end

    assign instr    = instr_valid ? w_head_instr : r_instr;
    assign instr_pc = instr_valid ? w_head_pc    : r_instr_pc;

    a_no_spurious_rvalid: assert property (
        @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (w_outstanding != '0)
    );

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage directly upstream of the ALU-only decoder. Owns the PC and issues word reads to instruction memory. Buffers returned instructions in a small in-order queue and presents them to the decoder over a valid/ready handshake. Supports a redirect input from the execute stage that flushes all in-flight and buffered fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
DEPTH, 2, instruction queue entries; also the cap on outstanding + buffered fetches (2..8)
CNT_W, 3, width of the occupancy/outstanding/kill counters; must hold DEPTH

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  read request this cycle
imem_addr  out  32  word-aligned read address, valid when imem_req=1
imem_rvalid  in  1  read data valid; responses arrive in order, at least 1 cycle after the request
imem_rdata  in  32  returned instruction word
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  32  new PC; bits [1:0] ignored (forced to 0)
instr_valid  out  1  instr/instr_pc hold a valid instruction
instr_ready  in  1  decoder accepts the instruction
instr  out  32  instruction word to the decoder
instr_pc  out  32  PC of instr

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. Asserting rst_n=0 at any time, including mid-fetch, immediately clears all state.
- Reset values: pc=RESET_PC, state=BOOT, queue empty, outstanding=0, kill=0. Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- FSM:
  - BOOT: one idle cycle after reset release, then RUN.
  - RUN: normal fetching. Enter FLUSH on redirect when the kill count after the update is nonzero.
  - FLUSH: discard responses until kill=0, then RUN. New requests may still issue in FLUSH.
- Issue: imem_req = (state!=BOOT) && (outstanding + count < DEPTH). This is combinational from registers only. imem_addr = pc.
- On an issue cycle, pc advances by 4 with 32-bit wrap (32'hFFFF_FFFC -> 0). Issue PCs are pushed into a PC FIFO that pairs each response with its address.
- Response: when imem_rvalid=1 and kill=0, {rdata, pc} is pushed into the queue and outstanding decrements. When kill>0, the response is dropped and both kill and outstanding decrement.
- Output: instr_valid = queue non-empty. instr and instr_pc come from the registered queue head. The head pops on instr_valid && instr_ready.
- Fetch latency: a request issued in cycle N with rvalid in cycle N+1 appears on instr_valid in cycle N+2.
- Full queue: no request is issued, so a response can never find the queue full.
- Empty queue: instr_valid=0, and instr/instr_pc hold their last values.
- Redirect (highest priority):
  - pc <= {redirect_pc[31:2],2'b00} and the queue is emptied.
  - kill <= outstanding_next, which counts any request issued this same cycle.
  - A handshake or response in the redirect cycle is discarded; instr_valid=0 on the next cycle.
- Back-to-back redirects: each one recomputes kill from the current outstanding count.
- imem_rvalid with outstanding=0 is a protocol error: assertion in simulation, ignored in RTL.

Optional Feature:
IFETCH_ILLEGAL_CHK_EN
- Defined: adds output port instr_illegal (1 bit), valid with instr_valid. It is 1 when instr[1:0]!=2'b11, or when opcode instr[6:0] is not 7'b0010011 or 7'b0110011 (the ALU ops the decoder handles). The flag is computed at queue push and stored per entry.
- Undefined: the port and its storage are absent; behaviour is otherwise identical.

Decomposition:
- Package ifetch_pkg:
  - fetch state enum (BOOT, RUN, FLUSH)
  - OPC_OP_IMM=7'b0010011 and OPC_OP=7'b0110011
  - INSTR_W=32 and PC_STEP=4
  - queue entry struct {instr, pc, illegal}
- Sub-module ifetch_fifo: parameterised synchronous FIFO with push/pop/flush and count output. It is instantiated twice: once as the instruction queue and once as the issued-PC FIFO.

Test Plan:
- Reset release, memory with 1-cycle latency, instr_ready=1 -> requests at 0x0, 0x4, 0x8… each cycle after BOOT; first instr_valid two cycles after the first request, with instr_pc=0x0.
- instr_ready=0 for 10 cycles, DEPTH=2 -> exactly 2 requests issued, imem_req stays 0 and the queue holds 0x0 and 0x4. Releasing ready delivers them in order, then fetching resumes at 0x8.
- Memory with 3-cycle latency, redirect_pc=0x103 asserted while 2 requests are outstanding -> both responses dropped, next request addr=0x100, first delivered instr_pc=0x100.
- Redirect in the same cycle as a handshake and a response -> neither counted, instr_valid=0 next cycle, no stale PC ever appears on instr_pc.
- rst_n pulsed low mid-FLUSH -> instr_valid=0 and imem_req=0 immediately; after release, fetching restarts at RESET_PC.
- With IFETCH_ILLEGAL_CHK_EN, return 32'h0000_0013 then 32'h0000_0003 -> instr_illegal = 0 then 1.
